// File: rtl/l1i_miss_handler_pkg.sv
// Shared types and constants for the L1 instruction-cache miss handler.
// Sizes, FSM encoding and the block-address alignment helper.
package l1i_miss_handler_pkg;

  localparam int SIZE_PC           = 32;
  localparam int SIZE_INSTRUCTION  = 64;
  localparam int BLOCK_INSTS       = 4;
  localparam int BLOCK_OFFSET_BITS = 5;
  localparam int BLOCK_W           = BLOCK_INSTS * SIZE_INSTRUCTION;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DRAIN,
    FILL
  } state_t;

  function automatic logic [SIZE_PC-1:0] block_align(input logic [SIZE_PC-1:0] addr);
    return {addr[SIZE_PC-1:BLOCK_OFFSET_BITS], {BLOCK_OFFSET_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/l1i_fill_buffer.sv
// Beat counter and slot storage for one returning instruction block.
// block_o already includes the beat arriving this cycle, so the 4th beat can be filled without delay.
module l1i_fill_buffer
  import l1i_miss_handler_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        beat_i,
  input  logic                        discard_i,
  input  logic [SIZE_INSTRUCTION-1:0] data_i,
  output logic                        last_o,
  output logic [BLOCK_W-1:0]          block_o
);

  localparam int CNT_W = $clog2(BLOCK_INSTS);

  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [SIZE_INSTRUCTION-1:0] slot_q [BLOCK_INSTS];
  logic                        write;

  assign write  = beat_i && !discard_i;
  assign last_o = beat_i && (cnt_q == CNT_W'(BLOCK_INSTS - 1));
  // Counter wraps to 0 on the 4th beat, ready for the next block.
  assign cnt_d  = beat_i ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (write) begin
      slot_q[cnt_q] <= data_i;
    end
  end

  always_comb begin
    block_o = '0;
    for (int k = 0; k < BLOCK_INSTS; k++) begin
      block_o[k*SIZE_INSTRUCTION +: SIZE_INSTRUCTION] =
        (write && (cnt_q == CNT_W'(k))) ? data_i : slot_q[k];
    end
  end

endmodule

// File: rtl/l1i_miss_handler.sv
// Single-entry L1 I-cache miss handler: one block request, 4-beat assembly, one-cycle fill.
// All outputs are registered from the next-state decode.
module l1i_miss_handler
  import l1i_miss_handler_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        miss_i,
  input  logic [SIZE_PC-1:0]          missAddr_i,
  input  logic                        flush_i,
  output logic                        memReq_o,
  output logic [SIZE_PC-1:0]          memAddr_o,
  input  logic                        memReady_i,
  input  logic                        memValid_i,
  input  logic [SIZE_INSTRUCTION-1:0] memData_i,
  output logic                        wrEnable_o,
  output logic [SIZE_PC-1:0]          wrAddr_o,
  output logic [BLOCK_W-1:0]          instBlock_o,
  output logic                        stall_o
);

  state_t               state_q, state_d;
  logic [SIZE_PC-1:0]   addr_q, addr_d;
  logic                 memReq_q, wrEnable_q, stall_q;
  logic [BLOCK_W-1:0]   instBlock_q;
  logic                 beat, discard, last;
  logic [BLOCK_W-1:0]   blockNext;

  assign beat    = memValid_i && ((state_q == WAIT) || (state_q == DRAIN));
  assign discard = (state_q == DRAIN);

  l1i_fill_buffer u_fill_buffer (
    .clk       (clk),
    .reset     (reset),
    .beat_i    (beat),
    .discard_i (discard),
    .data_i    (memData_i),
    .last_o    (last),
    .block_o   (blockNext)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        if (miss_i && !flush_i) begin
          addr_d  = block_align(missAddr_i);
          state_d = REQ;
        end
      end
      REQ: begin
        if (memReady_i) begin
          state_d = flush_i ? DRAIN : WAIT;
        end else if (flush_i) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        // A flush landing on the final beat has nothing left to drain.
        if (last) begin
          state_d = flush_i ? IDLE : FILL;
        end else if (flush_i) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (last) begin
          state_d = IDLE;
        end
      end
      FILL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      memReq_q    <= 1'b0;
      wrEnable_q  <= 1'b0;
      stall_q     <= 1'b0;
      instBlock_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      memReq_q   <= (state_d == REQ);
      wrEnable_q <= (state_d == FILL);
      stall_q    <= (state_d != IDLE);
      if (state_d == FILL) begin
        instBlock_q <= blockNext;
      end
    end
  end

  assign memReq_o    = memReq_q;
  assign memAddr_o   = addr_q;
  assign wrEnable_o  = wrEnable_q;
  assign wrAddr_o    = addr_q;
  assign instBlock_o = instBlock_q;
  assign stall_o     = stall_q;

endmodule
